// File: rtl/arduino_shift_rx_pkg.sv
// Shared constants, counter-width helper and receiver state type for arduino_shift_rx.
package arduino_shift_rx_pkg;

  localparam int DEFAULT_WIDTH       = 3;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } rx_state_t;

  // Bit counter must hold 0..WIDTH+1 so an over-long frame stays distinguishable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/arduino_shift_rx_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin, plus a history flop that flags rising edges.
module sync_edge_detect #(
  parameter int STAGES = arduino_shift_rx_pkg::DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              hist_q;
  logic              hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/arduino_shift_rx.sv
// Serial-to-parallel receiver for a 3-wire (clock/data/latch) shift link from an Arduino.
// Optional frame checking is enabled by defining ARDUINO_SHIFT_RX_FRAME_CHECK_EN.
module arduino_shift_rx
  import arduino_shift_rx_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_clk,
  input  logic             ser_data,
  input  logic             ser_latch,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             frame_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam int WW = $clog2(SYNC_STAGES + 2);

  logic clk_lvl, clk_rise_raw;
  logic data_lvl, data_rise_raw;
  logic latch_lvl, latch_rise_raw;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk),
    .rst   (rst),
    .din   (ser_clk),
    .level (clk_lvl),
    .rise  (clk_rise_raw)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clk),
    .rst   (rst),
    .din   (ser_data),
    .level (data_lvl),
    .rise  (data_rise_raw)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk   (clk),
    .rst   (rst),
    .din   (ser_latch),
    .level (latch_lvl),
    .rise  (latch_rise_raw)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, clk_lvl, data_rise_raw, latch_lvl};

  // Warm-up: history flops settle on the pin levels before any edge is honoured.
  logic [WW-1:0] warm_q, warm_d;
  logic          warm_done;

  assign warm_done = (warm_q == WW'(SYNC_STAGES + 1));

  always_comb begin
    warm_d = warm_q;
    if (!warm_done) warm_d = warm_q + WW'(1);
  end

  logic sclk_rise, latch_rise;
  assign sclk_rise  = clk_rise_raw & warm_done;
  assign latch_rise = latch_rise_raw & warm_done;

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             valid_q, valid_d;
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
  logic             ferr_q, ferr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    valid_d = 1'b0;
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
    ferr_d  = 1'b0;
`endif

    if (sclk_rise) begin
      shift_d = {shift_q[WIDTH-2:0], data_lvl};
      if (cnt_q != CW'(WIDTH + 1)) cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE:  if (sclk_rise) state_d = (cnt_d == CW'(WIDTH)) ? FULL : SHIFT;
      SHIFT: if (sclk_rise && cnt_d == CW'(WIDTH)) state_d = FULL;
      FULL:  if (sclk_rise) state_d = OVER;
      OVER:  state_d = OVER;
      default: state_d = IDLE;
    endcase

    // A latch coinciding with a shift sees the post-shift word and state.
    if (latch_rise) begin
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
      if (state_d == FULL) begin
        par_d   = shift_d;
        valid_d = 1'b1;
      end else begin
        ferr_d  = 1'b1;
      end
`else
      par_d   = shift_d;
      valid_d = 1'b1;
`endif
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      warm_q  <= warm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      valid_q <= valid_d;
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  assign par_out   = par_q;
  assign par_valid = valid_q;
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_arduino_shift_rx.sv
// Directed self-checking bench for arduino_shift_rx (WIDTH=3, SYNC_STAGES=2, ser_clk period 8 clk).
module tb_arduino_shift_rx;

  localparam int WIDTH = 3;
`ifdef ARDUINO_SHIFT_RX_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ser_clk = 1'b0;
  logic             ser_data = 1'b0;
  logic             ser_latch = 1'b0;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;

  arduino_shift_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_latch (ser_latch),
    .par_out   (par_out),
    .par_valid (par_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (par_valid) valid_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_bit(input logic b);
    ser_data = b;
    tick(4);
    ser_clk = 1'b1;
    tick(4);
    ser_clk = 1'b0;
  endtask

  task automatic do_latch();
    ser_latch = 1'b1;
    tick(4);
    ser_latch = 1'b0;
    tick(4);
    $display("latch: par_out=%b valid_total=%0d ferr_total=%0d", par_out, valid_cnt, ferr_cnt);
  endtask

  int v0, f0;

  initial begin
    // Reset state
    tick(3);
    check("rst_par_out", par_out, 0);
    check("rst_valid", par_valid, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick(5);

    // Frame 1,0,1 with latch timing
    v0 = valid_cnt; f0 = ferr_cnt;
    shift_bit(1); shift_bit(0); shift_bit(1);
    tick(1);
    ser_latch = 1'b1;
    tick(1);
    check("lat_k_valid", par_valid, 0);
    tick(1);
    check("lat_k1_valid", par_valid, 0);
    tick(1);
    check("lat_k2_valid", par_valid, 1);
    check("lat_k2_par", par_out, 3'b101);
    tick(1);
    check("lat_k3_valid", par_valid, 0);
    tick(1);
    ser_latch = 1'b0;
    tick(4);
    $display("latch: par_out=%b valid_total=%0d ferr_total=%0d", par_out, valid_cnt, ferr_cnt);
    check("f101_vcount", valid_cnt - v0, 1);
    check("f101_ferr", ferr_cnt - f0, 0);

    // Over-long frame 1,1,0,1,0
    v0 = valid_cnt; f0 = ferr_cnt;
    shift_bit(1); shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(0);
    check("over_cnt", dut.cnt_q, WIDTH + 1);
    do_latch();
    check("over_par", par_out, FC ? 3'b101 : 3'b010);
    check("over_vcount", valid_cnt - v0, FC ? 0 : 1);
    check("over_ferr", ferr_cnt - f0, FC ? 1 : 0);

    // Reset mid-frame
    shift_bit(1); shift_bit(1);
    rst = 1'b1;
    tick(3);
    check("midrst_par", par_out, 0);
    rst = 1'b0;
    tick(5);
    v0 = valid_cnt; f0 = ferr_cnt;
    do_latch();
    check("midrst_lat_par", par_out, 0);
    check("midrst_vcount", valid_cnt - v0, FC ? 0 : 1);
    check("midrst_ferr", ferr_cnt - f0, FC ? 1 : 0);

    // Pins high through reset release: no edges
    rst = 1'b1;
    ser_latch = 1'b1;
    ser_clk = 1'b1;
    tick(3);
    rst = 1'b0;
    v0 = valid_cnt; f0 = ferr_cnt;
    tick(20);
    check("warm_vcount", valid_cnt - v0, 0);
    check("warm_ferr", ferr_cnt - f0, 0);
    check("warm_cnt", dut.cnt_q, 0);
    ser_latch = 1'b0;
    ser_clk = 1'b0;
    tick(5);
    check("warm_cnt_fall", dut.cnt_q, 0);

    // Simultaneous shift and latch, then frame 0,0,1
    v0 = valid_cnt; f0 = ferr_cnt;
    shift_bit(1); shift_bit(1);
    ser_data = 1'b1;
    tick(4);
    ser_clk = 1'b1;
    ser_latch = 1'b1;
    tick(4);
    ser_clk = 1'b0;
    ser_latch = 1'b0;
    tick(4);
    $display("latch: par_out=%b valid_total=%0d ferr_total=%0d", par_out, valid_cnt, ferr_cnt);
    check("sim_par", par_out, 3'b111);
    check("sim_vcount", valid_cnt - v0, 1);
    check("sim_cnt", dut.cnt_q, 0);
    shift_bit(0); shift_bit(0); shift_bit(1);
    do_latch();
    check("f001_par", par_out, 3'b001);
    check("f001_vcount", valid_cnt - v0, 2);
    check("f001_ferr", ferr_cnt - f0, 0);

    // Full frame 1,1,0 then two latches
    shift_bit(1); shift_bit(1); shift_bit(0);
    v0 = valid_cnt; f0 = ferr_cnt;
    do_latch();
    check("dbl1_par", par_out, 3'b110);
    do_latch();
    check("dbl2_par", par_out, 3'b110);
    check("dbl_vcount", valid_cnt - v0, FC ? 1 : 2);
    check("dbl_ferr", ferr_cnt - f0, FC ? 1 : 0);

    // par_out holds between latches
    tick(30);
    check("hold_par", par_out, 3'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
